// File: rtl/vga_pkg.sv
// Shared constants, mode encodings and small helpers for the VGA timing pipe.
package vga_pkg;

  // 640x480 @ 60 Hz timing (25.175 MHz pixel clock)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Default colour channel widths (RGB332)
  localparam int VGA_RW = 3;
  localparam int VGA_GW = 3;
  localparam int VGA_BW = 2;

  // Output source selection
  typedef enum logic [1:0] {
    MODE_RENDER = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_BLACK  = 2'd3
  } mode_e;

  // True when lo <= pos < hi; used for sync window decoding.
  function automatic logic in_range(input logic [9:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_pipe_if.sv
// Renderer-facing bus: coordinates out, colour back after RENDER_LAT cycles.
interface vga_timing_pipe_if #(
  parameter int CW = 8
);
  logic [9:0]    sx;
  logic [9:0]    sy;
  logic          de;
  logic          frame_start;
  logic [CW-1:0] rgb_in;

  modport master (output sx, sy, de, frame_start, input rgb_in);
  modport slave  (input sx, sy, de, frame_start, output rgb_in);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line; depth 0 degenerates to a wire.
module vga_delay_line #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage_r [DEPTH];

      // Shift register; reset fills every stage with the idle value.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) stage_r[i] <= RST_VAL;
        end else begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// Display timing generator with latency-matched sync/blank and pattern mux.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int RENDER_LAT = 0,
  parameter int RW         = VGA_RW,
  parameter int GW         = VGA_GW,
  parameter int BW         = VGA_BW
) (
  input  logic                clk_pix,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [RW+GW+BW-1:0] solid_rgb,
  vga_timing_pipe_if.master   ren,
  output logic [15:0]         frame_count,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic [RW-1:0]       vga_r,
  output logic [GW-1:0]       vga_g,
  output logic [BW-1:0]       vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = RW + GW + BW;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int DLW     = 13;

  logic [9:0]    sx_r, sy_r, sx_nxt_s, sy_nxt_s;
  logic          de_r, fs_r, hs_act_r, vs_act_r;
  logic [15:0]   fc_r;
  mode_e         mode_r, mode_cur_s;
  logic [DLW-1:0] dl_in_s, dl_out_s;
  logic          hs_d_s, vs_d_s, de_d_s;
  logic [9:0]    sx_d_s;
  logic [2:0]    bar_s;
  logic [CW-1:0] colour_s;

  // Next raster position: wrap sx at line end, sy at frame end.
  always_comb begin
    sx_nxt_s = sx_r + 10'd1;
    sy_nxt_s = sy_r;
    if (sx_r == 10'(H_TOTAL - 1)) begin
      sx_nxt_s = 10'd0;
      if (sy_r == 10'(V_TOTAL - 1)) sy_nxt_s = 10'd0;
      else                          sy_nxt_s = sy_r + 10'd1;
    end else begin
      sx_nxt_s = sx_r + 10'd1;
    end
  end

  // Counter-aligned state: position flags are decoded from the next position so they line up with sx/sy.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      sx_r     <= 10'd0;
      sy_r     <= 10'd0;
      de_r     <= 1'b1;
      fs_r     <= 1'b1;
      hs_act_r <= 1'b0;
      vs_act_r <= 1'b0;
      fc_r     <= 16'd0;
      mode_r   <= MODE_RENDER;
    end else begin
      sx_r     <= sx_nxt_s;
      sy_r     <= sy_nxt_s;
      de_r     <= (int'(sx_nxt_s) < H_ACTIVE) && (int'(sy_nxt_s) < V_ACTIVE);
      fs_r     <= (sx_nxt_s == 10'd0) && (sy_nxt_s == 10'd0);
      hs_act_r <= in_range(sx_nxt_s, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
      vs_act_r <= in_range(sy_nxt_s, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
      if ((sx_r == 10'(H_TOTAL - 1)) && (sy_r == 10'(V_TOTAL - 1))) fc_r <= fc_r + 16'd1;
      if (fs_r) mode_r <= mode_e'(mode);
    end
  end

  assign ren.sx          = sx_r;
  assign ren.sy          = sy_r;
  assign ren.de          = de_r;
  assign ren.frame_start = fs_r;
  assign frame_count     = fc_r;

  // Match sync/blank/column to the renderer latency (sync stored as active flags, idle = 0).
  assign dl_in_s = {hs_act_r, vs_act_r, de_r, sx_r};

  vga_delay_line #(
    .W      (DLW),
    .DEPTH  (RENDER_LAT),
    .RST_VAL(13'd0)
  ) u_dly (
    .clk(clk_pix),
    .rst(rst),
    .d  (dl_in_s),
    .q  (dl_out_s)
  );

  assign {hs_d_s, vs_d_s, de_d_s, sx_d_s} = dl_out_s;

  // In the frame_start cycle the mode being latched already governs the new frame,
  // so pixel (0,0) uses it even with zero render latency.
  assign mode_cur_s = fs_r ? mode_e'(mode) : mode_r;

  // Colour source mux; blanking always forces black.
  always_comb begin
    bar_s    = 3'(sx_d_s / 10'(BAR_W));
    colour_s = '0;
    if (!de_d_s) begin
      colour_s = '0;
    end else begin
      case (mode_cur_s)
        MODE_RENDER: colour_s = ren.rgb_in;
        MODE_BARS:   colour_s = {{RW{bar_s[2]}}, {GW{bar_s[1]}}, {BW{bar_s[0]}}};
        MODE_SOLID:  colour_s = solid_rgb;
        MODE_BLACK:  colour_s = '0;
        default:     colour_s = '0;
      endcase
    end
  end

  // VGA pin register: sync at configured polarity, colour from the mux.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      vga_hsync <= ~H_POL;
      vga_vsync <= ~V_POL;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      vga_hsync <= hs_d_s ? H_POL : ~H_POL;
      vga_vsync <= vs_d_s ? V_POL : ~V_POL;
      {vga_r, vga_g, vga_b} <= colour_s;
    end
  end

endmodule

// File: doc/vga_timing_pipe.md
# vga_timing_pipe

Parametrised display timing and pixel-output pipeline for the VGA path. It drives pixel coordinates to the renderer (`screen` or a successor) and takes back the renderer's colour after a fixed render latency. It aligns sync and blanking to that latency, muxes in built-in test patterns, and registers the VGA pins. It sits between the pixel-clock generator and the board VGA connector.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- H_POL / V_POL, 0 / 0, sync active level (0 = active-low)
- RENDER_LAT, 0, cycles from sx/sy to matching rgb_in (0..7)
- RW / GW / BW, 3 / 3 / 2, colour channel widths

Ports:
- clk_pix  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- mode  in  2  0 renderer, 1 colour bars, 2 solid, 3 black
- solid_rgb  in  RW+GW+BW  colour for mode 2, {r,g,b}
- rgb_in  in  RW+GW+BW  renderer colour, {r,g,b}
- sx, sy  out  10 each  current counter coordinates to the renderer
- de  out  1  counter-aligned active-area flag
- frame_start  out  1  one-cycle pulse at sx=0, sy=0
- frame_count  out  16  frames completed, wraps
- vga_hsync, vga_vsync  out  1 each  registered sync pins
- vga_r / vga_g / vga_b  out  RW / GW / BW  registered colour pins

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL is defined the same way (525).
- sx counts 0..H_TOTAL-1. At sx=H_TOTAL-1, sx wraps to 0 and sy increments. sy wraps to 0 after V_TOTAL-1.
- de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
- hsync is active for H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on sy. Both are driven at the level set by the polarity parameters.
- Delay line: {hsync, vsync, de, sx} is delayed by RENDER_LAT cycles, giving hs_d, vs_d, de_d, sx_d.
- The mode register is captured only when frame_start is high. A mode change mid-frame takes effect at the next frame.
- Colour selection uses de_d:
  - de_d low: colour = 0.
  - mode 0: rgb_in.
  - mode 1: bar = sx_d / (H_ACTIVE/8), 3 bits. r = all-ones if bar[2], g = all-ones if bar[1], b = all-ones if bar[0].
  - mode 2: solid_rgb.
  - mode 3: 0.
- frame_count increments when sy=V_TOTAL-1 and sx=H_TOTAL-1. It wraps 0xFFFF→0.
- Reset values:
  - sx = 0, sy = 0, frame_count = 0, mode register = 0.
  - Delay line filled with inactive sync, de = 0, sx = 0.
  - vga_hsync = inactive level (!H_POL), vga_vsync = !V_POL.
  - Colour pins = 0.
- Reset mid-frame restarts timing at (0,0). frame_start is high in the first cycle after reset is released.

## Timing
- sx, sy, de and frame_start are registered and mutually aligned.
- VGA pins lag the counter state by exactly RENDER_LAT+1 cycles: the delay line plus one output register.
- With RENDER_LAT=0 the delay line is bypassed. rgb_in is sampled combinationally from sx/sy.
- No handshake. The renderer must honour RENDER_LAT exactly.

## Structure
- Package vga_pkg:
  - 640x480@60 timing constants.
  - Mode encodings (MODE_RENDER, MODE_BARS, MODE_SOLID, MODE_BLACK).
  - Colour-width defaults.
- Sub-module vga_delay_line: parametrised width and depth. Depth 0 is a pass-through. Reset value is supplied by parameter.
- The pixel-clock generator stays outside. This block is a pure clk_pix domain block.

## Test plan
- Release reset, run 2 frames. Check:
  - frame_start period = 420000 cycles.
  - hsync low for 96 cycles starting at sx=656.
  - vsync low on sy=490..491.
  - frame_count = 2 at the third frame_start.
- RENDER_LAT=3, renderer returns rgb = sx[7:0] delayed 3 → pin colour at cycle t+4 equals the value for sx at t. Pins are 0 when de_d is low.
- Mode 1 at start of frame → on a visible line, colour at pins changes every 80 pixels in the sequence 000, 00F…, ending with all-ones for bar 7.
- Switch mode 0→2 at sy=200 → output remains renderer colour until the next frame_start, then equals solid_rgb (e.g. 0xA5) throughout the active area.
- Assert rst at sx=300, sy=100 for 5 cycles. Check:
  - Pins immediately go to inactive sync and black.
  - After release, sx = 0, sy = 0 and frame_start is pulsed once.
- H_POL=1, V_POL=1 → sync pins idle low and pulse high with unchanged widths. Preload frame_count = 0xFFFF via a forced run → it wraps to 0.
